output_port_allocator: RTL and testbench
========================================

Name: output_port_allocator

Overview:
- Per-output-port switch allocator for the mesh router. One instance sits behind each crossbar output.
- Input ports request the output using the look-ahead port number carried in their head flit. The block grants one input round-robin and holds that grant for the whole packet (wormhole lock, head to tail).
- It tracks downstream buffer credits and only issues a crossbar write strobe when a credit is available.

Parameters:
- PORT_NUM, 5, number of router ports; also the width of the request and grant vectors.
- OUT_PORT, 1, index of the output this instance serves: 0 LOCAL, 1 EAST, 2 NORTH, 3 WEST, 4 SOUTH.
- BUF_DEPTH, 4, flit slots in the downstream input buffer; also the reset credit value.
- CREDIT_WIDTH, log2(BUF_DEPTH+1), width of the credit counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_req  in  PORT_NUM  bit i set: input i has a flit at its head addressed to OUT_PORT.
- in_tail  in  PORT_NUM  bit i set: the head flit of input i is a tail flit (a single-flit packet has head and tail both set).
- credit_in  in  1  one-cycle pulse: the downstream buffer freed one slot.
- grant  out  PORT_NUM  one-hot (or zero) crossbar select / input read enable owner.
- out_wr_en  out  1  a flit traverses the crossbar this cycle.
- credit_cnt  out  CREDIT_WIDTH  current free downstream slots.
- busy  out  1  output locked to a packet.
- credit_err  out  1  sticky: credit_in was received while credit_cnt == BUF_DEPTH.

Behaviour:
- Reset values: grant=0, out_wr_en=0, busy=0, credit_cnt=BUF_DEPTH, credit_err=0. Round-robin pointer = 0 and FSM = IDLE.
- Request masking (U-turn prohibition):
  - If OUT_PORT != 0, use eff_req = in_req with bit OUT_PORT forced to 0.
  - If OUT_PORT == 0, use eff_req = in_req unchanged.
- FSM states: IDLE and LOCKED. busy = (state == LOCKED).
- IDLE:
  - If eff_req != 0, register the winner: the first set bit of eff_req, searching upward from the pointer with wrap-around.
  - Next cycle: state = LOCKED and grant = one-hot(winner).
  - Arbitration does not wait for credits.
  - Grant latency is exactly 1 cycle from the first cycle a request is seen.
- LOCKED:
  - grant is held constant. The owner is the set bit of grant.
  - out_wr_en = busy & in_req[owner] & (credit_cnt != 0). This is combinational within the cycle.
  - If the owner drops in_req, the lock is held and no transfer occurs (bubble).
  - Other requests are ignored while locked.
- Tail handling:
  - On a cycle with out_wr_en=1 and in_tail[owner]=1, the next state is IDLE and grant=0.
  - The pointer is set to (owner+1) mod PORT_NUM.
  - The earliest re-arbitration decision is made in the IDLE cycle that follows, so there is one idle cycle between packets. This is required behaviour.
- Credit counter:
  - Next value = credit_cnt - out_wr_en + credit_in.
  - When both occur in the same cycle, the value is unchanged.
  - out_wr_en is never asserted at credit_cnt == 0, so the counter cannot underflow.
  - credit_in at credit_cnt == BUF_DEPTH with no simultaneous write: the counter saturates at BUF_DEPTH and credit_err is set. credit_err clears only on reset.
- Reset asserted mid-packet: on the next edge, all state returns to reset values, including credits and the pointer. No out_wr_en is asserted in the reset cycle.
- Width rules: the pointer is log2(PORT_NUM) bits and wraps explicitly at PORT_NUM, not at a power of two.

Decomposition:
- Shared package/define file holds:
  - port index constants LOCAL=0, EAST=1, NORTH=2, WEST=3, SOUTH=4 (shared with look-ahead routing);
  - the log2 function;
  - the FSM state encodings.
- One natural sub-module: rr_arbiter.
  - Combinational round-robin select of a one-hot winner from req and pointer, parameterised by PORT_NUM.
  - Instantiated once; it is reused later by VC allocation.

Test Plan:
- Reset, then OUT_PORT=1, in_req=5'b00100, in_tail=5'b00100 (single flit) -> grant=5'b00100 one cycle later; out_wr_en=1 that cycle; credit_cnt 4->3; then grant=0 and the pointer points to port 3.
- in_req=5'b10101 held, 3-flit packets (tail on third transfer), credit_in pulsed after each write -> owners granted in order 0,2,4,0. Each packet gives exactly 3 out_wr_en pulses and one idle cycle between packets.
- OUT_PORT=1, in_req=5'b00010 only -> grant stays 0 and busy stays 0 (U-turn masked). With OUT_PORT=0, the same request for port 0 is granted.
- Locked owner with 5-flit packet and no credit_in -> 4 transfers; credit_cnt=0; out_wr_en=0 while grant is held. One credit_in pulse -> 1 transfer the next cycle.
- credit_in pulsed at credit_cnt=4 with no write -> credit_cnt stays 4 and credit_err=1 sticky. Same cycle as out_wr_en -> count unchanged and no error.
- Reset asserted mid-packet (2 of 4 flits sent, credit_cnt=2) -> next cycle grant=0, busy=0, credit_cnt=4, pointer=0. A new request is granted normally after reset is released.

Source files
------------

// File: rtl/output_port_allocator_pkg.sv
// Shared definitions for the output port allocator.
// Port indices are shared with look-ahead routing.
package output_port_allocator_pkg;

  localparam int LOCAL = 0;
  localparam int EAST  = 1;
  localparam int NORTH = 2;
  localparam int WEST  = 3;
  localparam int SOUTH = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Width needed to hold values 0..value-1 (never less than one bit).
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or
// above ptr, wrapping at PORT_NUM, and returns it one-hot and as an index.
module rr_arbiter
  import output_port_allocator_pkg::*;
#(
  parameter int PORT_NUM = 5,
  parameter int PTR_W    = clog2(PORT_NUM)
) (
  input  logic [PORT_NUM-1:0] req,
  input  logic [PTR_W-1:0]    ptr,
  output logic [PORT_NUM-1:0] gnt,
  output logic [PTR_W-1:0]    gnt_idx
);

  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < PORT_NUM; i++) begin
      for (int j = 0; j < PORT_NUM; j++) begin
        if (!found && req[j] && (j == ((int'(ptr) + i) % PORT_NUM))) begin
          gnt[j]  = 1'b1;
          gnt_idx = PTR_W'(j);
          found   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/output_port_allocator.sv
// Per-output switch allocator: round-robin grant held for a whole packet
// (wormhole lock) and credit-gated crossbar write strobe.
module output_port_allocator
  import output_port_allocator_pkg::*;
#(
  parameter int PORT_NUM     = 5,
  parameter int OUT_PORT     = EAST,
  parameter int BUF_DEPTH    = 4,
  parameter int CREDIT_WIDTH = clog2(BUF_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PORT_NUM-1:0]     in_req,
  input  logic [PORT_NUM-1:0]     in_tail,
  input  logic                    credit_in,
  output logic [PORT_NUM-1:0]     grant,
  output logic                    out_wr_en,
  output logic [CREDIT_WIDTH-1:0] credit_cnt,
  output logic                    busy,
  output logic                    credit_err
);

  localparam int PTR_W = clog2(PORT_NUM);
  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(PORT_NUM - 1);

  state_t              state;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    owner;
  logic [PORT_NUM-1:0] eff_req;
  logic [PORT_NUM-1:0] win_gnt;
  logic [PTR_W-1:0]    win_idx;
  logic                owner_req;
  logic                owner_tail;

  // A packet never turns back out of the port it arrived on, except LOCAL.
  always_comb begin
    eff_req = in_req;
    if (OUT_PORT != LOCAL) eff_req[OUT_PORT] = 1'b0;
  end

  rr_arbiter #(
    .PORT_NUM (PORT_NUM),
    .PTR_W    (PTR_W)
  ) u_rr_arbiter (
    .req     (eff_req),
    .ptr     (ptr),
    .gnt     (win_gnt),
    .gnt_idx (win_idx)
  );

  assign owner_req  = |(grant & in_req);
  assign owner_tail = |(grant & in_tail);
  assign busy       = (state == LOCKED);

  // Handshake: the owner's in_req acts as valid, a free credit as ready;
  // out_wr_en marks the transfer and the owning input pops its head flit.
  assign out_wr_en = !reset && busy && owner_req && (credit_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
      owner <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|eff_req) begin
            state <= LOCKED;
            grant <= win_gnt;
            owner <= win_idx;
          end
        end
        LOCKED: begin
          if (out_wr_en && owner_tail) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= (owner == LAST_PORT) ? '0 : owner + 1'b1;
          end
        end
      endcase
    end
  end

  // A write and a returning credit in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      credit_cnt <= CREDIT_MAX;
      credit_err <= 1'b0;
    end else if (credit_in && !out_wr_en) begin
      if (credit_cnt == CREDIT_MAX) credit_err <= 1'b1;
      else                          credit_cnt <= credit_cnt + 1'b1;
    end else if (!credit_in && out_wr_en) begin
      credit_cnt <= credit_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator: each expected write {grant, credit_cnt}
// is queued by the stimulus and popped by a monitor whenever out_wr_en is seen.
module tb_output_port_allocator;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] in_req, in_tail;
  logic       credit_in;
  logic [4:0] grant;
  logic       out_wr_en;
  logic [2:0] credit_cnt;
  logic       busy, credit_err;

  logic [4:0] req0, tail0;
  logic [4:0] grant0;
  logic       wr0, busy0, err0;
  logic [2:0] cnt0;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  output_port_allocator #(.PORT_NUM(5), .OUT_PORT(1), .BUF_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_req(in_req), .in_tail(in_tail),
    .credit_in(credit_in), .grant(grant), .out_wr_en(out_wr_en),
    .credit_cnt(credit_cnt), .busy(busy), .credit_err(credit_err)
  );

  output_port_allocator #(.PORT_NUM(5), .OUT_PORT(0), .BUF_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .in_req(req0), .in_tail(tail0),
    .credit_in(1'b0), .grant(grant0), .out_wr_en(wr0),
    .credit_cnt(cnt0), .busy(busy0), .credit_err(err0)
  );

  // Monitor: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    if (out_wr_en !== 1'b0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got grant=%b cnt=%0d wr=%b, required no write",
                 grant, credit_cnt, out_wr_en);
      end else begin
        exp_v = exp_q.pop_front();
        if ({grant, credit_cnt} !== exp_v) begin
          n_fail++;
          $display("FAIL wr_match: got grant=%b cnt=%0d, required grant=%b cnt=%0d",
                   grant, credit_cnt, exp_v[7:3], exp_v[2:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic c);
    in_req    = r;
    in_tail   = t;
    credit_in = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] g, input logic [2:0] c);
    exp_q.push_back({g, c});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(5'b0, 5'b0, 1'b0);
    req0  = 5'b0;
    tail0 = 5'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_wr", 32'(out_wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(credit_cnt), 32'd4);
    check("rst_err", 32'(credit_err), 32'd0);
    step();
  endtask

  task automatic check_q_empty(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int owners[4];
    logic [4:0] oh;
    owners = '{0, 2, 4, 0};

    do_reset();

    // Single-flit packet from port 2, then pointer must sit at port 3.
    drive(5'b00100, 5'b00100, 1'b0);
    @(negedge clk);
    check("s1_idle_grant", 32'(grant), 32'd0);
    step();
    push(5'b00100, 3'd4);
    @(negedge clk);
    check("s1_grant", 32'(grant), 32'b00100);
    check("s1_busy", 32'(busy), 32'd1);
    step();
    drive(5'b01001, 5'b01001, 1'b0);
    @(negedge clk);
    check("s1_released", 32'(grant), 32'd0);
    check("s1_cnt", 32'(credit_cnt), 32'd3);
    step();
    push(5'b01000, 3'd3);
    @(negedge clk);
    check("s1_ptr3_grant", 32'(grant), 32'b01000);
    step();
    drive(5'b0, 5'b0, 1'b0);
    @(negedge clk);
    check("s1_end_busy", 32'(busy), 32'd0);
    check("s1_end_cnt", 32'(credit_cnt), 32'd2);
    check_q_empty("s1_q_empty");
    step();

    // Three-flit packets from ports 0,2,4 held, credits returned after each write.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      oh = 5'b00001 << owners[p];
      for (int c = 0; c < 4; c++) begin
        drive(5'b10101, (c == 3) ? oh : 5'b0, (c >= 2) || (c == 0 && p > 0));
        if (c >= 1) push(oh, (c == 1) ? 3'd4 : 3'd3);
        @(negedge clk);
        if (c == 0) check("s2_gap_busy", 32'(busy), 32'd0);
        else        check("s2_owner", 32'(grant), 32'(oh));
        step();
      end
    end
    drive(5'b0, 5'b0, 1'b1);
    @(negedge clk);
    check("s2_end_busy", 32'(busy), 32'd0);
    step();
    drive(5'b0, 5'b0, 1'b0);
    @(negedge clk);
    check("s2_cnt", 32'(credit_cnt), 32'd4);
    check("s2_err", 32'(credit_err), 32'd0);
    check_q_empty("s2_q_empty");
    step();

    // U-turn request is masked on EAST; the LOCAL instance grants port 0.
    do_reset();
    drive(5'b00010, 5'b00010, 1'b0);
    req0  = 5'b00001;
    tail0 = 5'b00001;
    @(negedge clk);
    check("s3_c0_grant", 32'(grant), 32'd0);
    step();
    @(negedge clk);
    check("s3_uturn_grant", 32'(grant), 32'd0);
    check("s3_uturn_busy", 32'(busy), 32'd0);
    check("s3_local_grant", 32'(grant0), 32'b00001);
    check("s3_local_wr", 32'(wr0), 32'd1);
    step();
    drive(5'b0, 5'b0, 1'b0);
    req0  = 5'b0;
    tail0 = 5'b0;
    @(negedge clk);
    check("s3_uturn_busy2", 32'(busy), 32'd0);
    check("s3_local_cnt", 32'(cnt0), 32'd3);
    step();

    // Five-flit packet with no returned credits: stall at zero, resume on one credit.
    do_reset();
    drive(5'b00100, 5'b0, 1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      push(5'b00100, 3'(4 - k));
      @(negedge clk);
      check("s4_grant", 32'(grant), 32'b00100);
      step();
    end
    @(negedge clk);
    check("s4_stall_wr", 32'(out_wr_en), 32'd0);
    check("s4_stall_grant", 32'(grant), 32'b00100);
    check("s4_stall_cnt", 32'(credit_cnt), 32'd0);
    step();
    drive(5'b00100, 5'b0, 1'b1);
    @(negedge clk);
    check("s4_stall_wr2", 32'(out_wr_en), 32'd0);
    step();
    drive(5'b00100, 5'b00100, 1'b0);
    push(5'b00100, 3'd1);
    @(negedge clk);
    step();
    drive(5'b0, 5'b0, 1'b0);
    @(negedge clk);
    check("s4_end_busy", 32'(busy), 32'd0);
    check("s4_end_cnt", 32'(credit_cnt), 32'd0);
    check_q_empty("s4_q_empty");
    step();

    // Credit with a simultaneous write is neutral; a credit at full count is an error.
    do_reset();
    drive(5'b01000, 5'b01000, 1'b0);
    step();
    drive(5'b01000, 5'b01000, 1'b1);
    push(5'b01000, 3'd4);
    @(negedge clk);
    step();
    drive(5'b0, 5'b0, 1'b0);
    @(negedge clk);
    check("s5_same_cnt", 32'(credit_cnt), 32'd4);
    check("s5_same_err", 32'(credit_err), 32'd0);
    step();
    drive(5'b0, 5'b0, 1'b1);
    @(negedge clk);
    step();
    drive(5'b0, 5'b0, 1'b0);
    @(negedge clk);
    check("s5_sat_cnt", 32'(credit_cnt), 32'd4);
    check("s5_err_set", 32'(credit_err), 32'd1);
    step();
    @(negedge clk);
    check("s5_err_sticky", 32'(credit_err), 32'd1);
    step();

    // Reset mid-packet (pointer is at port 4 beforehand) returns everything to reset values.
    drive(5'b10000, 5'b0, 1'b0);
    step();
    push(5'b10000, 3'd4);
    step();
    push(5'b10000, 3'd3);
    step();
    reset = 1'b1;
    @(negedge clk);
    check("s6_rst_wr", 32'(out_wr_en), 32'd0);
    check("s6_mid_cnt", 32'(credit_cnt), 32'd2);
    step();
    reset = 1'b0;
    drive(5'b10001, 5'b00001, 1'b0);
    @(negedge clk);
    check("s6_grant", 32'(grant), 32'd0);
    check("s6_busy", 32'(busy), 32'd0);
    check("s6_cnt", 32'(credit_cnt), 32'd4);
    check("s6_err", 32'(credit_err), 32'd0);
    step();
    push(5'b00001, 3'd4);
    @(negedge clk);
    check("s6_ptr0_grant", 32'(grant), 32'b00001);
    step();
    drive(5'b0, 5'b0, 1'b0);
    @(negedge clk);
    check("s6_end_busy", 32'(busy), 32'd0);
    check("s6_end_cnt", 32'(credit_cnt), 32'd3);
    check_q_empty("s6_q_empty");
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
